ico_servo_capture: RTL



---
 rtl/ico_servo_pkg.sv | 22 ++
 rtl/ico_servo_capture_if.sv | 14 +
 rtl/ico_servo_pin_meas.sv | 47 ++++
 rtl/ico_servo_capture.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ico_servo_pkg.sv
// Constants and types shared by the servo PWM generator and the servo capture block.
package ico_servo_pkg;

  localparam int unsigned TICK_BITS   = 11;
  localparam int unsigned FRAME_TICKS = 1 << TICK_BITS;
  localparam int unsigned START_SHIFT = 3;
  localparam int unsigned WIDTH_MAX   = 255;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_LO   = 2'd1,
    RD_HI   = 2'd2
  } rd_state_t;

  // A pulse that rises and falls within one tick still reports width 1.
  function automatic logic [7:0] clamp_width(input logic [TICK_BITS-1:0] diff);
    if (diff == '0)                        return 8'd1;
    else if (diff > TICK_BITS'(WIDTH_MAX)) return 8'(WIDTH_MAX);
    else                                   return diff[7:0];
  endfunction

endpackage

// File: rtl/ico_servo_capture_if.sv
// SPI control endpoint signals plus endpoint select, shared with the generator slot.
interface ico_servo_capture_if;
  logic       spi_ctrl_si;
  logic       spi_ctrl_so;
  logic       spi_ctrl_hd;
  logic [7:0] spi_ctrl_di;
  logic [7:0] spi_ctrl_do;
  logic [1:0] epsel;

  modport master (output spi_ctrl_si, spi_ctrl_so, spi_ctrl_hd, spi_ctrl_di, epsel,
                  input  spi_ctrl_do);
  modport slave  (input  spi_ctrl_si, spi_ctrl_so, spi_ctrl_hd, spi_ctrl_di, epsel,
                  output spi_ctrl_do);
endinterface

// File: rtl/ico_servo_pin_meas.sv
// One capture pin: 2-FF synchroniser, edge detect, rise time and clamped width.
module ico_servo_pin_meas
  import ico_servo_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_pin,
  input  logic [TICK_BITS-1:0] i_timer,
  output logic                 o_done,
  output logic [15:0]          o_result
);

  logic [1:0]           r_sync;
  logic                 r_prev;
  logic                 r_armed;
  logic [TICK_BITS-1:0] r_rise_t;
  logic                 w_rise;
  logic                 w_fall;
  logic [TICK_BITS-1:0] w_diff;

  assign w_rise = r_sync[1] & ~r_prev;
  assign w_fall = ~r_sync[1] & r_prev;
  // Modular subtraction handles pulses that straddle the timer wrap.
  assign w_diff = i_timer - r_rise_t;

  assign o_done   = w_fall & r_armed;
  assign o_result = {8'(r_rise_t >> START_SHIFT), clamp_width(w_diff)};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_armed  <= 1'b0;
      r_rise_t <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_prev <= r_sync[1];
      if (w_rise) begin
        r_rise_t <= i_timer;
        r_armed  <= 1'b1;
      end else if (w_fall) begin
        r_armed  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ico_servo_capture.sv
// Servo pulse capture: 10 us timebase, per-frame publish and SPI readback of start/width bytes.
module ico_servo_capture
  import ico_servo_pkg::*;
#(
  parameter int NUM_PMODS = 1,
  parameter int CLK_KHZ   = 12000
) (
  input  logic                   clk,
  input  logic                   resetn,
  ico_servo_capture_if.slave     spi,
  input  logic [8*NUM_PMODS-1:0] pmod_i,
  output logic [8*NUM_PMODS-1:0] pmod_o,
  output logic [8*NUM_PMODS-1:0] pmod_d
);

  localparam int unsigned NPINS = 8 * NUM_PMODS;
  localparam int unsigned PRESC = CLK_KHZ / 100;
  localparam int unsigned PW    = $clog2(PRESC + 1);

  logic [PW-1:0]        r_presc;
  logic [TICK_BITS-1:0] r_timer;
  logic                 w_tick;
  logic                 w_frame;
  logic [NPINS-1:0]     w_done;
  logic [15:0]          w_result [NPINS];
  logic [15:0]          r_work   [NPINS];
  logic [15:0]          r_pub    [NPINS];
  rd_state_t            r_rd_state;
  logic [7:0]           r_rd_addr;
  logic [7:0]           r_do;
  logic [15:0]          w_sel;
  logic [7:0]           w_byte;
  logic                 w_unused_so;

  assign pmod_o          = '0;
  assign pmod_d          = '0;
  assign spi.spi_ctrl_do = r_do;
  assign w_unused_so     = spi.spi_ctrl_so;

  assign w_tick  = (r_presc == PW'(PRESC - 1));
  assign w_frame = w_tick && (r_timer == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
      r_timer <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_timer <= r_timer + TICK_BITS'(1);
    end
  end

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    ico_servo_pin_meas u_meas (
      .clk      (clk),
      .resetn   (resetn),
      .i_pin    (pmod_i[g]),
      .i_timer  (r_timer),
      .o_done   (w_done[g]),
      .o_result (w_result[g])
    );
  end

  // A fall on the boundary cycle bypasses work so it lands in the frame that just ended.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NPINS; i++) begin
        r_work[i] <= '0;
        r_pub[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NPINS; i++) begin
        if (w_frame) begin
          r_pub[i]  <= w_done[i] ? w_result[i] : r_work[i];
          r_work[i] <= '0;
        end else if (w_done[i]) begin
          r_work[i] <= w_result[i];
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NPINS; i++) begin
      if (r_rd_addr == 8'(i)) w_sel = r_pub[i];
    end
    case (r_rd_state)
      RD_LO:   w_byte = w_sel[7:0];
      RD_HI:   w_byte = w_sel[15:8];
      default: w_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= RD_IDLE;
      r_rd_addr  <= '0;
      r_do       <= '0;
    end else begin
      r_do <= w_byte;
      case (r_rd_state)
        RD_IDLE: begin
          if (spi.spi_ctrl_hd && spi.spi_ctrl_si) begin
            r_rd_addr <= spi.spi_ctrl_di;
            if (spi.epsel[1])      r_rd_state <= RD_HI;
            else if (spi.epsel[0]) r_rd_state <= RD_LO;
          end
        end
        RD_LO: begin
          if (!spi.epsel[0])       r_rd_state <= RD_IDLE;
          else if (spi.spi_ctrl_si) r_rd_addr <= r_rd_addr + 8'd1;
        end
        RD_HI: begin
          if (!spi.epsel[1])       r_rd_state <= RD_IDLE;
          else if (spi.spi_ctrl_si) r_rd_addr <= r_rd_addr + 8'd1;
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
